// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - 2-bit FSM state encodings (FETCH, DRAIN, HALTED)
//   - F/D pipeline register width and field offsets
//   - default bubble instruction (ADD r0,r0,r0)
//   - make_fd(): packs {valid, pc_plus_2, instruction} into an F/D word
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam int FD_WIDTH    = 33;
   localparam int FD_VALID    = 32;
   localparam int FD_PC2_HI   = 31;
   localparam int FD_PC2_LO   = 16;
   localparam int FD_INSTR_HI = 15;
   localparam int FD_INSTR_LO = 0;

   localparam logic [15:0] DEFAULT_NOP = 16'h0000;

   function automatic logic [FD_WIDTH-1:0] make_fd(input logic        valid,
                                                    input logic [15:0] pc2,
                                                    input logic [15:0] instr);
      logic [FD_WIDTH-1:0] w;
      w                           = '0;
      w[FD_VALID]                 = valid;
      w[FD_PC2_HI:FD_PC2_LO]      = pc2;
      w[FD_INSTR_HI:FD_INSTR_LO]  = instr;
      return w;
   endfunction

endpackage

// File: rtl/adder_16bit.sv
// -----------------------------------------------------------------------------
// adder_16bit
// 16-bit adder/subtractor, result modulo 2^16.
//   a, b : operands
//   sub  : 0 -> a + b, 1 -> a - b (two's complement)
//   sum  : result
// -----------------------------------------------------------------------------
module adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   output logic [15:0] sum
);

   // Subtraction is a + ~b + 1; the carry-in is the sub bit itself.
   assign sum = a + (b ^ {16{sub}}) + {15'd0, sub};

endmodule

// File: rtl/fetch_hold_buffer.sv
// -----------------------------------------------------------------------------
// fetch_hold_buffer
// One-entry holding register for an instruction returned by memory while
// decode is stalled.
//   clk, rst          : clock, async active-high reset
//   load              : capture pc2_in/instr_in and set valid
//   clear             : drop the entry (valid <= 0)
//   pc2_in, instr_in  : entry to capture
//   valid, pc2, instr : held entry
// -----------------------------------------------------------------------------
module fetch_hold_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [15:0] pc2_in,
   input  logic [15:0] instr_in,
   output logic        valid,
   output logic [15:0] pc2,
   output logic [15:0] instr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         pc2   <= 16'h0000;
         instr <= 16'h0000;
      end else if (load) begin
         valid <= 1'b1;
         pc2   <= pc2_in;
         instr <= instr_in;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Instruction-fetch stage of the 16-bit 5-stage pipeline. Owns the PC, drives
// the instruction-memory port and produces the F/D register for decode.
//   clk, rst       : clock, async active-high reset
//   stall          : decode/hazard stall, hold F/D
//   flush          : taken branch, redirect to branch_target
//   branch_target  : redirect address
//   halt           : HLT is in decode
//   imem_req       : memory request
//   imem_addr      : fetch address
//   imem_rdata     : returned instruction
//   imem_ready     : request completes this cycle
//   fd_out         : {valid, pc_plus_2, instruction}
//   fetch_pc       : current PC (trace)
//   halted         : HALTED state reached
//
// Memory handshake: a transfer completes on any rising edge where
// imem_req=1 and imem_ready=1 (ready may rise in the request cycle). While
// imem_req=1 and imem_ready=0, imem_addr is held stable. A request once issued
// cannot be withdrawn, so a redirect or halt that arrives while it is pending
// goes through DRAIN to absorb and discard the response.
// -----------------------------------------------------------------------------
module fetch
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = DEFAULT_NOP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic [15:0]         branch_target,
   input  logic                halt,
   output logic                imem_req,
   output logic [15:0]         imem_addr,
   input  logic [15:0]         imem_rdata,
   input  logic                imem_ready,
   output logic [FD_WIDTH-1:0] fd_out,
   output logic [15:0]         fetch_pc,
   output logic                halted
);

   logic [1:0]          state_q, state_d;
   logic [15:0]         pc_q, pc_d;
   logic [15:0]         req_addr_q, req_addr_d;
   logic                halt_pend_q, halt_pend_d;
   logic [FD_WIDTH-1:0] fd_q, fd_d;
   logic [15:0]         pc_plus_2;
   logic                buf_load, buf_clear, buf_valid;
   logic [15:0]         buf_pc2, buf_instr;
   logic [FD_WIDTH-1:0] bubble;

   assign bubble = make_fd(1'b0, 16'h0000, NOP_INSTR);

   adder_16bit u_pc_adder (
      .a   (pc_q),
      .b   (16'h0002),
      .sub (1'b0),
      .sum (pc_plus_2)
   );

   fetch_hold_buffer u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .clear    (buf_clear),
      .pc2_in   (pc_plus_2),
      .instr_in (imem_rdata),
      .valid    (buf_valid),
      .pc2      (buf_pc2),
      .instr    (buf_instr)
   );

   // A buffered instruction means no new request until decode takes it.
   assign imem_req  = ((state_q == ST_FETCH) && !buf_valid) || (state_q == ST_DRAIN);
   assign imem_addr = (state_q == ST_DRAIN) ? req_addr_q : pc_q;
   assign fd_out    = fd_q;
   assign fetch_pc  = pc_q;
   assign halted    = (state_q == ST_HALTED);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      halt_pend_d = halt_pend_q;
      fd_d        = fd_q;
      buf_load    = 1'b0;
      buf_clear   = 1'b0;

      case (state_q)
         ST_FETCH: begin
            // Track the address in flight so DRAIN can keep presenting it
            // after pc_q has been redirected.
            req_addr_d = pc_q;
            if (buf_valid) begin
               if (flush) begin
                  buf_clear = 1'b1;
                  pc_d      = branch_target;
                  fd_d      = bubble;
               end else if (stall) begin
                  fd_d = fd_q;
               end else if (halt) begin
                  buf_clear = 1'b1;
                  fd_d      = bubble;
                  state_d   = ST_HALTED;
               end else begin
                  buf_clear = 1'b1;
                  fd_d      = make_fd(1'b1, buf_pc2, buf_instr);
               end
            end else if (imem_ready) begin
               if (flush) begin
                  pc_d = branch_target;
                  fd_d = bubble;
               end else if (stall) begin
                  buf_load = 1'b1;
                  pc_d     = pc_plus_2;
               end else if (halt) begin
                  fd_d    = bubble;
                  state_d = ST_HALTED;
               end else begin
                  fd_d = make_fd(1'b1, pc_plus_2, imem_rdata);
                  pc_d = pc_plus_2;
               end
            end else begin
               if (flush) begin
                  pc_d        = branch_target;
                  fd_d        = bubble;
                  halt_pend_d = 1'b0;
                  state_d     = ST_DRAIN;
               end else if (stall) begin
                  fd_d = fd_q;
               end else if (halt) begin
                  fd_d        = bubble;
                  halt_pend_d = 1'b1;
                  state_d     = ST_DRAIN;
               end else begin
                  fd_d = bubble;
               end
            end
         end

         ST_DRAIN: begin
            if (flush) begin
               pc_d = branch_target;
            end
            if (!(stall && !flush)) begin
               fd_d = bubble;
            end
            if (imem_ready) begin
               state_d     = halt_pend_q ? ST_HALTED : ST_FETCH;
               halt_pend_d = 1'b0;
            end
         end

         ST_HALTED: begin
            fd_d = bubble;
         end

         default: begin
            state_d = ST_FETCH;
            fd_d    = bubble;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         req_addr_q  <= RESET_PC;
         halt_pend_q <= 1'b0;
         fd_q        <= make_fd(1'b0, 16'h0000, NOP_INSTR);
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         halt_pend_q <= halt_pend_d;
         fd_q        <= fd_d;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch
// Self-checking bench for fetch: a directed vector table from reset, a few
// hand-written multi-cycle sequences, then randomized stimulus compared every
// cycle against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch;

   logic        clk;
   logic        rst;
   logic        stall, flush, halt;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic [32:0] fd_out;
   logic [15:0] fetch_pc;
   logic        halted;

   logic        mem_rand;
   logic [15:0] rand_data;

   int n_checks;
   int n_fail;

   localparam logic [32:0] BUBBLE = 33'h0_0000_0000;

   fetch dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .halt          (halt),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .fd_out        (fd_out),
      .fetch_pc      (fetch_pc),
      .halted        (halted)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Directed memory returns 16'h1000 + address; random mode returns noise.
   always_comb imem_rdata = mem_rand ? rand_data : (16'h1000 + imem_addr);

   // ---------------- check helpers ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk33(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic s, input logic f, input logic h,
                        input logic r, input logic [15:0] t);
      stall         = s;
      flush         = f;
      halt          = h;
      imem_ready    = r;
      branch_target = t;
   endtask

   // Asynchronous pulse placed between clock edges.
   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   logic [15:0] m_pc;
   logic [32:0] m_fd;
   logic [31:0] m_buf[$];       // {pc_plus_2, instr} awaiting decode
   logic        m_wrongpath;    // a request whose answer must be thrown away
   logic [15:0] m_old_addr;
   logic        m_halt_after;
   logic        m_halted;
   int          m_halt_cycles;

   function automatic logic m_req();
      return !m_halted && (m_wrongpath || (m_buf.size() == 0));
   endfunction

   function automatic logic [15:0] m_addr();
      return m_wrongpath ? m_old_addr : m_pc;
   endfunction

   task automatic model_reset();
      m_pc          = 16'h0000;
      m_fd          = BUBBLE;
      m_buf.delete();
      m_wrongpath   = 1'b0;
      m_old_addr    = 16'h0000;
      m_halt_after  = 1'b0;
      m_halted      = 1'b0;
      m_halt_cycles = 0;
   endtask

   task automatic model_step(input logic s, input logic f, input logic h,
                             input logic r, input logic [15:0] t,
                             input logic [15:0] data);
      logic [31:0] e;
      if (m_halted) begin
         m_fd = BUBBLE;
      end else if (m_wrongpath) begin
         if (f) m_pc = t;
         if (!(s && !f)) m_fd = BUBBLE;
         if (r) begin
            m_wrongpath = 1'b0;
            if (m_halt_after) m_halted = 1'b1;
            m_halt_after = 1'b0;
         end
      end else if (m_buf.size() != 0) begin
         if (f) begin
            e = m_buf.pop_front();
            m_pc = t;
            m_fd = BUBBLE;
         end else if (s) begin
            // everything waits
         end else if (h) begin
            e = m_buf.pop_front();
            m_fd = BUBBLE;
            m_halted = 1'b1;
         end else begin
            e = m_buf.pop_front();
            m_fd = {1'b1, e};
         end
      end else if (r) begin
         if (f) begin
            m_pc = t;
            m_fd = BUBBLE;
         end else if (s) begin
            m_buf.push_back({m_pc + 16'd2, data});
            m_pc = m_pc + 16'd2;
         end else if (h) begin
            m_fd = BUBBLE;
            m_halted = 1'b1;
         end else begin
            m_fd = {1'b1, m_pc + 16'd2, data};
            m_pc = m_pc + 16'd2;
         end
      end else begin
         if (f) begin
            m_old_addr   = m_pc;
            m_wrongpath  = 1'b1;
            m_halt_after = 1'b0;
            m_pc         = t;
            m_fd         = BUBBLE;
         end else if (s) begin
            // F/D held, request keeps waiting
         end else if (h) begin
            m_old_addr   = m_pc;
            m_wrongpath  = 1'b1;
            m_halt_after = 1'b1;
            m_fd         = BUBBLE;
         end else begin
            m_fd = BUBBLE;
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        stall;
      logic        flush;
      logic        halt;
      logic        ready;
      logic [15:0] target;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic [32:0] exp_fd;
      logic [15:0] exp_pc;
      logic        exp_halted;
   } vec_t;

   vec_t vecs[19];

   // ---------------- main test ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      mem_rand = 1'b0;
      rand_data = 16'h0000;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

      // Inputs are applied before the edge; expectations are the outputs
      // seen in that same cycle (before the edge takes effect).
      //            st fl ha rd target    req addr      fd               pc        hlt
      vecs[0]  = '{0, 0, 0, 1, 16'h0000, 1, 16'h0000, 33'h0_0000_0000, 16'h0000, 0};
      vecs[1]  = '{0, 0, 0, 1, 16'h0000, 1, 16'h0002, 33'h1_0002_1000, 16'h0002, 0};
      vecs[2]  = '{1, 0, 0, 1, 16'h0000, 1, 16'h0004, 33'h1_0004_1002, 16'h0004, 0};
      vecs[3]  = '{1, 0, 0, 1, 16'h0000, 0, 16'h0000, 33'h1_0004_1002, 16'h0006, 0};
      vecs[4]  = '{1, 0, 0, 1, 16'h0000, 0, 16'h0000, 33'h1_0004_1002, 16'h0006, 0};
      vecs[5]  = '{0, 0, 0, 1, 16'h0000, 0, 16'h0000, 33'h1_0004_1002, 16'h0006, 0};
      vecs[6]  = '{0, 0, 0, 1, 16'h0000, 1, 16'h0006, 33'h1_0006_1004, 16'h0006, 0};
      vecs[7]  = '{0, 1, 0, 1, 16'h0040, 1, 16'h0008, 33'h1_0008_1006, 16'h0008, 0};
      vecs[8]  = '{0, 0, 0, 1, 16'h0000, 1, 16'h0040, 33'h0_0000_0000, 16'h0040, 0};
      vecs[9]  = '{0, 0, 0, 0, 16'h0000, 1, 16'h0042, 33'h1_0042_1040, 16'h0042, 0};
      vecs[10] = '{0, 0, 0, 0, 16'h0000, 1, 16'h0042, 33'h0_0000_0000, 16'h0042, 0};
      vecs[11] = '{0, 0, 0, 1, 16'h0000, 1, 16'h0042, 33'h0_0000_0000, 16'h0042, 0};
      vecs[12] = '{0, 1, 0, 0, 16'h0080, 1, 16'h0044, 33'h1_0044_1042, 16'h0044, 0};
      vecs[13] = '{0, 0, 0, 0, 16'h0000, 1, 16'h0044, 33'h0_0000_0000, 16'h0080, 0};
      vecs[14] = '{0, 0, 0, 1, 16'h0000, 1, 16'h0044, 33'h0_0000_0000, 16'h0080, 0};
      vecs[15] = '{0, 0, 0, 1, 16'h0000, 1, 16'h0080, 33'h0_0000_0000, 16'h0080, 0};
      vecs[16] = '{0, 0, 1, 1, 16'h0000, 1, 16'h0082, 33'h1_0082_1080, 16'h0082, 0};
      vecs[17] = '{1, 1, 0, 1, 16'h0100, 0, 16'h0000, 33'h0_0000_0000, 16'h0082, 1};
      vecs[18] = '{0, 0, 0, 1, 16'h0000, 0, 16'h0000, 33'h0_0000_0000, 16'h0082, 1};

      // Reset state, checked while rst is still asserted.
      #12;
      chk1 ("reset_req",    imem_req, 1'b1);
      chk33("reset_fd",     fd_out,   BUBBLE);
      chk16("reset_pc",     fetch_pc, 16'h0000);
      chk1 ("reset_halted", halted,   1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].stall, vecs[i].flush, vecs[i].halt, vecs[i].ready, vecs[i].target);
         #1;
         chk1 ($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
         if (vecs[i].exp_req)
            chk16($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
         chk33($sformatf("vec%0d_fd", i), fd_out, vecs[i].exp_fd);
         chk16($sformatf("vec%0d_pc", i), fetch_pc, vecs[i].exp_pc);
         chk1 ($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halted);
      end

      // ---- Sequence: PC wrap at FFFE, then halt while a request is pending.
      pulse_reset();
      chk1 ("seqa_after_rst_halted", halted, 1'b0);
      chk16("seqa_after_rst_addr", imem_addr, 16'h0000);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      #1;
      chk16("seqa_addr_fffe", imem_addr, 16'hFFFE);
      chk33("seqa_flush_bubble", fd_out, BUBBLE);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      #1;
      chk33("seqa_wrap_fd", fd_out, 33'h1_0000_0FFE);
      chk16("seqa_wrap_pc", fetch_pc, 16'h0000);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk1 ("seqa_drain_req", imem_req, 1'b1);
      chk16("seqa_drain_addr", imem_addr, 16'h0000);
      chk1 ("seqa_drain_not_halted", halted, 1'b0);
      chk33("seqa_drain_bubble", fd_out, BUBBLE);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      #1;
      chk1 ("seqa_still_draining", halted, 1'b0);
      @(negedge clk);
      #1;
      chk1 ("seqa_halted", halted, 1'b1);
      chk1 ("seqa_halted_req", imem_req, 1'b0);

      // ---- Sequence: reset while a request to 0FFE is outstanding.
      pulse_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0FFE);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      #1;
      chk16("seqb_pending_addr", imem_addr, 16'h0FFE);
      chk16("seqb_pending_pc", fetch_pc, 16'h0FFE);
      pulse_reset();
      chk16("seqb_rst_pc", fetch_pc, 16'h0000);
      chk16("seqb_rst_addr", imem_addr, 16'h0000);
      chk1 ("seqb_rst_req", imem_req, 1'b1);
      chk33("seqb_rst_fd", fd_out, BUBBLE);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      @(negedge clk);
      #1;
      chk33("seqb_first_fd", fd_out, 33'h1_0002_1000);

      // ---- Randomized phase against the reference model.
      mem_rand = 1'b1;
      pulse_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         logic s, f, h, r;
         logic [15:0] t;
         if (c != 0) begin
            @(negedge clk);
            if ((m_halted && m_halt_cycles > 4) || ($urandom_range(0, 299) == 0)) begin
               rst = 1'b1;
               #2;
               rst = 1'b0;
               model_reset();
            end
            #1;
         end
         chk1 ("rnd_req", imem_req, m_req());
         if (m_req()) chk16("rnd_addr", imem_addr, m_addr());
         chk33("rnd_fd", fd_out, m_fd);
         chk16("rnd_pc", fetch_pc, m_pc);
         chk1 ("rnd_halted", halted, m_halted);
         if (m_halted) m_halt_cycles++;

         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 9) == 0);
         h = ($urandom_range(0, 39) == 0);
         r = ($urandom_range(0, 1) == 0);
         t = 16'($urandom_range(0, 32767)) << 1;
         rand_data = 16'($urandom_range(0, 65535));
         drive(s, f, h, r, t);
         model_step(s, f, h, r, t, rand_data);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
